// File: rtl/override_sched.sv
// -----------------------------------------------------------------------------
// override_sched
//
// Purpose:
//   Holds a single register q that normally takes ordinary writes. Requesters
//   can claim timed "continuous override" windows during which q follows the
//   granted requester's source word every cycle and ordinary writes are locked
//   out. Requesters share the register under round-robin arbitration. Each
//   window is followed by a one-cycle RELEASE state before the block returns
//   to IDLE.
//
// Optional feature (macro OVERRIDE_SCHED_RESTORE_EN):
//   When defined, the pre-window value of q is captured on the grant edge.
//   That capture includes a write that coincides with the grant. The captured
//   value is restored into q during RELEASE. When undefined, q keeps the last
//   overridden sample until the next ordinary write.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   wr_en      in   ordinary write strobe
//   wr_data    in   ordinary write value                     [WIDTH]
//   req        in   level-sensitive override requests        [NREQ]
//   req_data   in   source words, requester i at [i*WIDTH +: WIDTH]
//   req_len    in   window lengths, requester i at [i*LENW +: LENW] (0 => 1)
//   q          out  held register value                      [WIDTH]
//   grant      out  one-hot, one-cycle grant pulse           [NREQ]
//   ovr_active out  high while in OVERRIDE or RELEASE
//   owner      out  index of current / last granted requester
//   wr_dropped out  one-cycle pulse when a write was ignored
// -----------------------------------------------------------------------------
module override_sched #(
    parameter int              WIDTH     = 4,
    parameter int              NREQ      = 2,
    parameter int              LENW      = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    localparam int             OW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*WIDTH-1:0]  req_data,
    input  logic [NREQ*LENW-1:0]   req_len,
    output logic [WIDTH-1:0]       q,
    output logic [NREQ-1:0]        grant,
    output logic                   ovr_active,
    output logic [OW-1:0]          owner,
    output logic                   wr_dropped
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_OVERRIDE = 2'd1,
        ST_RELEASE  = 2'd2
    } state_e;

    localparam logic [LENW-1:0] LEN_ONE = LENW'(1);
    localparam logic [OW-1:0]   OW_ONE  = OW'(1);
    localparam logic [OW-1:0]   OW_LAST = OW'(NREQ - 1);
    localparam logic [NREQ-1:0] N_ONE   = NREQ'(1);

    // Registered state and outputs
    state_e             state_q;
    logic [WIDTH-1:0]   data_q;
    logic [NREQ-1:0]    grant_q;
    logic               ovr_q;
    logic [OW-1:0]      owner_q;     // also serves as the window's source select
    logic               drop_q;
    logic [OW-1:0]      ptr_q;
    logic [LENW-1:0]    cnt_q;
`ifdef OVERRIDE_SCHED_RESTORE_EN
    logic [WIDTH-1:0]   shadow_q;
`endif

    // Arbitration results for the current cycle
    logic               arb_hit_s;
    logic [OW-1:0]      arb_win_s;
    logic [LENW-1:0]    arb_len_s;
    logic [LENW-1:0]    arb_load_s;
    logic [OW-1:0]      ptr_nxt_s;
    logic [WIDTH-1:0]   src_s;

    // Round-robin pick: the first asserted request at or after the pointer.
    function automatic logic [OW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [OW-1:0]   p);
        logic [OW-1:0] w;
        logic          found;
        int            idx;
        w     = {OW{1'b0}};
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(p) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end else begin
                idx = idx;
            end
            if (!found && r[idx]) begin
                w     = OW'(idx);
                found = 1'b1;
            end else begin
                w     = w;
                found = found;
            end
        end
        return w;
    endfunction

    // Arbiter winner, its effective window length (0 promoted to 1) and the
    // pointer value that follows it.
    always_comb begin
        arb_hit_s = |req;
        arb_win_s = rr_pick(req, ptr_q);
        arb_len_s = req_len[int'(arb_win_s)*LENW +: LENW];
        if (arb_len_s == {LENW{1'b0}}) begin
            arb_load_s = LEN_ONE;
        end else begin
            arb_load_s = arb_len_s;
        end
        if (arb_win_s == OW_LAST) begin
            ptr_nxt_s = {OW{1'b0}};
        end else begin
            ptr_nxt_s = arb_win_s + OW_ONE;
        end
    end

    // Source word of the requester that owns the window.
    assign src_s = req_data[int'(owner_q)*WIDTH +: WIDTH];

    // Override FSM: sequences IDLE -> OVERRIDE (L samples) -> RELEASE (1 cycle).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            data_q   <= RESET_VAL;
            grant_q  <= {NREQ{1'b0}};
            ovr_q    <= 1'b0;
            owner_q  <= {OW{1'b0}};
            drop_q   <= 1'b0;
            ptr_q    <= {OW{1'b0}};
            cnt_q    <= {LENW{1'b0}};
`ifdef OVERRIDE_SCHED_RESTORE_EN
            shadow_q <= RESET_VAL;
`endif
        end else begin
            // Pulses default low; the states below raise them for one cycle.
            grant_q <= {NREQ{1'b0}};
            drop_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // A write and a grant on the same edge both take effect;
                    // the override starts replacing q from the next edge.
                    if (wr_en) begin
                        data_q <= wr_data;
                    end
                    if (arb_hit_s) begin
                        owner_q <= arb_win_s;
                        cnt_q   <= arb_load_s;
                        grant_q <= N_ONE << arb_win_s;
                        ovr_q   <= 1'b1;
                        ptr_q   <= ptr_nxt_s;
                        state_q <= ST_OVERRIDE;
`ifdef OVERRIDE_SCHED_RESTORE_EN
                        shadow_q <= wr_en ? wr_data : data_q;
`endif
                    end
                end
                ST_OVERRIDE: begin
                    // cnt counts the samples still to be taken, so it never
                    // goes below 1 here and never wraps.
                    data_q <= src_s;
                    cnt_q  <= cnt_q - LEN_ONE;
                    drop_q <= wr_en;
                    if (cnt_q == LEN_ONE) begin
                        state_q <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
`ifdef OVERRIDE_SCHED_RESTORE_EN
                    data_q <= shadow_q;
`endif
                    drop_q  <= wr_en;
                    ovr_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    ovr_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign q          = data_q;
    assign grant      = grant_q;
    assign ovr_active = ovr_q;
    assign owner      = owner_q;
    assign wr_dropped = drop_q;

endmodule

// File: tb/tb_override_sched.sv
// -----------------------------------------------------------------------------
// tb_override_sched
//
// Directed bench for override_sched (WIDTH=4, NREQ=2, LENW=4, RESET_VAL=0).
// A window-level reference model predicts all outputs each cycle, and hand
// computed literal expectations pin the key scenarios. Honours
// OVERRIDE_SCHED_RESTORE_EN for the restore-on-release behaviour.
// -----------------------------------------------------------------------------
module tb_override_sched;

    localparam int W  = 4;
    localparam int N  = 2;
    localparam int LW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [W-1:0]      wr_data;
    logic [N-1:0]      req;
    logic [N*W-1:0]    req_data;
    logic [N*LW-1:0]   req_len;
    logic [W-1:0]      q;
    logic [N-1:0]      grant;
    logic              ovr_active;
    logic [0:0]        owner;
    logic              wr_dropped;

    override_sched #(.WIDTH(W), .NREQ(N), .LENW(LW), .RESET_VAL(4'd0)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .req        (req),
        .req_data   (req_data),
        .req_len    (req_len),
        .q          (q),
        .grant      (grant),
        .ovr_active (ovr_active),
        .owner      (owner),
        .wr_dropped (wr_dropped)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;
    int ovr_hi = 0;

    // Window-level model: a window is described by its grant edge number,
    // its length and its owner; everything else follows from edge arithmetic.
    int         cyc       = 0;
    int         m_ptr     = 0;
    bit         have_win  = 1'b0;
    int         win_start = 0;
    int         win_len   = 0;
    int         win_own   = 0;
    logic [3:0] m_q       = 4'd0;
    logic [3:0] m_shadow  = 4'd0;
    logic [1:0] m_grant   = 2'd0;
    logic       m_ovr     = 1'b0;
    logic       m_drop    = 1'b0;
    int         m_owner   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_step();
        int j;
        int l;
        cyc++;
        m_grant = 2'd0;
        m_drop  = 1'b0;
        if (rst) begin
            m_q      = 4'd0;
            m_ovr    = 1'b0;
            m_owner  = 0;
            m_ptr    = 0;
            have_win = 1'b0;
        end else if (have_win && cyc <= win_start + win_len) begin
            m_q    = req_data[win_own*W +: W];
            m_drop = wr_en;
            m_ovr  = 1'b1;
        end else if (have_win && cyc == win_start + win_len + 1) begin
            m_drop = wr_en;
`ifdef OVERRIDE_SCHED_RESTORE_EN
            m_q    = m_shadow;
`endif
            m_ovr    = 1'b0;
            have_win = 1'b0;
        end else begin
            if (wr_en) m_q = wr_data;
            for (int i = 0; i < N; i++) begin
                j = (m_ptr + i) % N;
                if (!have_win && req[j]) begin
                    l         = int'(req_len[j*LW +: LW]);
                    have_win  = 1'b1;
                    win_start = cyc;
                    win_len   = (l == 0) ? 1 : l;
                    win_own   = j;
                    m_shadow  = m_q;
                    m_owner   = j;
                    m_grant   = 2'(1 << j);
                    m_ovr     = 1'b1;
                    m_ptr     = (j + 1) % N;
                end
            end
        end
    endfunction

    // Compare DUT outputs against the model each cycle, away from the edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_q",          q,          m_q);
            chk("model_grant",      grant,      m_grant);
            chk("model_ovr_active", ovr_active, m_ovr);
            chk("model_owner",      owner,      m_owner);
            chk("model_wr_dropped", wr_dropped, m_drop);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (ovr_active) ovr_hi++;
    endtask

    task automatic set_src(input int i, input logic [3:0] d, input logic [3:0] l);
        req_data[i*W +: W]  = d;
        req_len[i*LW +: LW] = l;
    endtask

    logic [1:0] gr_val [8];
    logic [0:0] gr_own [8];
    int         gr_cyc [8];
    int         n_gr;

    initial begin
        for (int k = 0; k < 8; k++) begin
            gr_val[k] = 2'd0;
            gr_own[k] = 1'b0;
            gr_cyc[k] = 0;
        end
        rst = 1'b1; wr_en = 1'b0; wr_data = 4'd0;
        req = 2'b00; req_data = 8'd0; req_len = 8'd0;
        chk_en = 1'b1;
        tick();
        chk("reset_q", q, 4'd0);
        chk("reset_ovr", ovr_active, 1'b0);
        chk("reset_grant", grant, 2'b00);
        chk("reset_owner", owner, 1'b0);

        // Reset then write
        rst = 1'b0; wr_en = 1'b1; wr_data = 4'd5;
        tick();
        wr_en = 1'b0;
        chk("write_q", q, 4'd5);
        chk("write_grant", grant, 2'b00);

        // Window with changing source, writes during OVERRIDE and RELEASE
        req = 2'b01; set_src(0, 4'd2, 4'd5); ovr_hi = 0;
        tick();
        req = 2'b00;
        chk("win_grant", grant, 2'b01);
        chk("win_q_pre", q, 4'd5);
        tick(); chk("win_s1", q, 4'd2);
        wr_en = 1'b1; wr_data = 4'd9;
        tick(); wr_en = 1'b0;
        chk("win_s2", q, 4'd2);
        chk("lock_drop_ovr", wr_dropped, 1'b1);
        tick(); chk("win_s3", q, 4'd2);
        set_src(0, 4'd3, 4'd5);
        tick(); chk("win_s4", q, 4'd3);
        tick(); chk("win_s5", q, 4'd3);
        chk("win_release_ovr", ovr_active, 1'b1);
        wr_en = 1'b1; wr_data = 4'd9;
        tick(); wr_en = 1'b0;
        chk("lock_drop_rel", wr_dropped, 1'b1);
        chk("win_end_ovr", ovr_active, 1'b0);
`ifdef OVERRIDE_SCHED_RESTORE_EN
        chk("win_after_q", q, 4'd5);
`else
        chk("win_after_q", q, 4'd3);
`endif
        chk("win_ovr_cycles", ovr_hi, 6);
        wr_en = 1'b1; wr_data = 4'd9;
        tick();
        chk("idle_write9", q, 4'd9);
        wr_data = 4'd7;
        tick(); wr_en = 1'b0;
        chk("idle_write7", q, 4'd7);

        // Round robin from a fresh pointer
        rst = 1'b1; tick(); rst = 1'b0;
        req = 2'b11; set_src(0, 4'd1, 4'd1); set_src(1, 4'hA, 4'd1);
        n_gr = 0;
        for (int k = 0; k < 9; k++) begin
            tick();
            if (grant != 2'b00 && n_gr < 8) begin
                gr_val[n_gr] = grant;
                gr_own[n_gr] = owner;
                gr_cyc[n_gr] = k;
                n_gr++;
            end
        end
        req = 2'b00;
        chk("rr_count", n_gr, 3);
        chk("rr_g0", gr_val[0], 2'b01);
        chk("rr_g1", gr_val[1], 2'b10);
        chk("rr_g2", gr_val[2], 2'b01);
        chk("rr_own0", gr_own[0], 1'b0);
        chk("rr_own1", gr_own[1], 1'b1);
        chk("rr_own2", gr_own[2], 1'b0);
        chk("rr_space01", gr_cyc[1] - gr_cyc[0], 3);
        chk("rr_space12", gr_cyc[2] - gr_cyc[1], 3);

        // Zero length acts as one sample
        set_src(0, 4'd6, 4'd0); req = 2'b01; ovr_hi = 0;
        tick(); req = 2'b00;
        chk("zl_grant", grant, 2'b01);
        tick(); chk("zl_sample", q, 4'd6);
        tick(); tick();
        chk("zl_ovr_cycles", ovr_hi, 2);

        // Reset aborts a long window
        set_src(0, 4'd11, 4'd8); req = 2'b01;
        tick(); req = 2'b00;
        tick(); tick();
        chk("abort_pre_q", q, 4'd11);
        rst = 1'b1;
        tick(); rst = 1'b0;
        chk("abort_q", q, 4'd0);
        chk("abort_ovr", ovr_active, 1'b0);
        chk("abort_grant", grant, 2'b00);
        tick();
        chk("abort_idle_ovr", ovr_active, 1'b0);
        chk("abort_idle_q", q, 4'd0);

        // Restore scenario: q=5, window len 2 with data 12
        wr_en = 1'b1; wr_data = 4'd5;
        tick(); wr_en = 1'b0;
        set_src(0, 4'd12, 4'd2); req = 2'b01;
        tick(); req = 2'b00;
        tick(); chk("rs_s1", q, 4'd12);
        tick(); chk("rs_s2", q, 4'd12);
        tick();
`ifdef OVERRIDE_SCHED_RESTORE_EN
        chk("rs_release_q", q, 4'd5);
`else
        chk("rs_release_q", q, 4'd12);
`endif
        chk("rs_release_ovr", ovr_active, 1'b0);

        // Write coincident with the grant edge
        req = 2'b01; wr_en = 1'b1; wr_data = 4'd4;
        tick(); req = 2'b00; wr_en = 1'b0;
        chk("co_q", q, 4'd4);
        chk("co_grant", grant, 2'b01);
        tick(); tick(); tick();
`ifdef OVERRIDE_SCHED_RESTORE_EN
        chk("co_release_q", q, 4'd4);
`else
        chk("co_release_q", q, 4'd12);
`endif
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
